mdio_ctrl: RTL and testbench

Clause-22 MDIO/SMI management master for the board's Ethernet PHY. It accepts single register read or write requests over a valid/ready handshake and serialises each one as an IEEE 802.3 management frame on MDC/MDIO. It returns read data and a turnaround error flag. It sits at chip level beside the RGMII path and replaces the tied-off MDC/MDIO pins; the pad tristate is built at chip level from mdio_o/mdio_oe.

---
 rtl/mdio_pkg.sv | 34 +++
 rtl/mdc_divider.sv | 41 ++++
 rtl/mdio_ctrl.sv | 143 ++++++++++++++
 tb/tb_mdio_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and frame-building helper for the
// Clause-22 MDIO management master.
package mdio_pkg;

  // Clause-22 frame field codes.
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA (32 bits).
  // For reads the TA/DATA slots are filled with ones; they are never driven
  // because mdio_oe is low for those bits.
  function automatic logic [31:0] frame_tail(input logic       write,
                                             input logic [4:0] phy,
                                             input logic [4:0] regad,
                                             input logic [15:0] wdata);
    logic [31:0] tail;
    if (write) begin
      tail = {ST_CODE, OP_WRITE, phy, regad, TA_WRITE, wdata};
    end else begin
      tail = {ST_CODE, OP_READ, phy, regad, 2'b11, 16'hFFFF};
    end
    return tail;
  endfunction

endpackage

// File: rtl/mdc_divider.sv
// MDC generator: counts 0..CLK_DIV-1 while enabled and toggles mdc on each
// wrap, so one MDC period is 2*CLK_DIV clk cycles. When disabled it parks
// with mdc=0 and the counter cleared, so the first enabled cycle is the
// start of a fresh low phase.
module mdc_divider #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(CLK_DIV - 1));

  // Strobes are high in the cycle whose closing clk edge flips mdc, so a
  // consumer that acts on the strobe changes state in the same edge as mdc.
  assign rise_stb = en && at_end && !mdc;
  assign fall_stb = en && at_end && mdc;

  // Half-period counter and mdc toggle; restart low whenever disabled.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (at_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_ctrl.sv
// Clause-22 MDIO/SMI management master. Accepts one register read or write
// at a time and serialises it as a management frame on MDC/MDIO, then
// reports read data and a turnaround fault flag.
//
// Handshake: a request transfers on a clk edge where req_valid and req_ready
// are both high. req_ready is high only in IDLE; requests presented while it
// is low are ignored (no queueing). rsp_valid is a one-cycle pulse, and
// rsp_rdata/rsp_err hold their values until the next completion.
module mdio_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV       = 10,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic [1:0]  state_dbg
);

  // Bit positions within the frame (bit 0 is the first bit on the wire).
  localparam int         N_BITS  = PREAMBLE_BITS + 32;
  localparam logic [5:0] LAST    = 6'(N_BITS - 1);
  localparam logic [5:0] OE_LAST = 6'(PREAMBLE_BITS + 13); // REGAD[0]
  localparam logic [5:0] TA2     = 6'(PREAMBLE_BITS + 15); // second TA bit
  localparam logic [5:0] DATA0   = 6'(PREAMBLE_BITS + 16); // DATA[15]

  state_t      state;
  logic [5:0]  bit_idx;
  logic [63:0] sr;        // shift-out register, current bit at [63]
  logic [15:0] shin;      // shift-in register for read data
  logic        ta_err;
  logic        is_write;
  logic        mdio_q;    // registered pad input
  logic [63:0] load_word;
  logic        div_en;
  logic        rise_stb;
  logic        fall_stb;

  assign req_ready = (state == IDLE);
  assign state_dbg = state;
  assign div_en    = (state != IDLE);
  assign mdio_o    = sr[63];

  // Whole frame left-justified: the preamble ones sit above the 32-bit tail
  // and the surplus preamble is shifted out of the top.
  assign load_word = {32'hFFFF_FFFF, frame_tail(req_write, req_phy, req_reg, req_wdata)}
                     << (32 - PREAMBLE_BITS);

  mdc_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (div_en),
    .mdc      (mdc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Controller FSM with bit counter, shift-out/shift-in and response regs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      sr        <= '1;
      shin      <= '0;
      ta_err    <= 1'b0;
      is_write  <= 1'b0;
      mdio_q    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      mdio_q    <= mdio_i;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= FRAME;
            is_write <= req_write;
            sr       <= load_word;
            bit_idx  <= '0;
            mdio_oe  <= 1'b1;
            ta_err   <= 1'b0;
            shin     <= '0;
          end
        end
        FRAME: begin
          // Reads sample the registered pad on the mdc rising edge.
          if (rise_stb && !is_write) begin
            if (bit_idx == TA2) begin
              ta_err <= mdio_q;
            end
            if (bit_idx >= DATA0) begin
              shin <= {shin[14:0], mdio_q};
            end
          end
          // Outputs advance only together with the mdc falling edge.
          if (fall_stb) begin
            if (bit_idx == LAST) begin
              state   <= GAP;
              sr      <= '1;
              mdio_oe <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sr      <= {sr[62:0], 1'b1};
              mdio_oe <= is_write || (bit_idx < OE_LAST);
            end
          end
        end
        GAP: begin
          // One idle MDC period, then complete and reopen for requests.
          if (fall_stb) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            if (is_write) begin
              rsp_err <= 1'b0;
            end else begin
              rsp_err   <= ta_err;
              rsp_rdata <= shin;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_ctrl.sv
// Bench for mdio_ctrl: two instances (CLK_DIV=4/PREAMBLE=32 and
// CLK_DIV=2/PREAMBLE=0) checked cycle by cycle against a bit-timeline model
// derived from frame layout and bit timing arithmetic.
module tb_mdio_ctrl;

  logic        clk;
  logic        reset;
  logic        rv1, rv2;
  logic        req_write;
  logic [4:0]  req_phy, req_reg;
  logic [15:0] req_wdata;
  logic        mdio_i;

  logic        rdy1, rdy2, vld1, vld2, err1, err2;
  logic [15:0] rd1, rd2;
  logic        mdc1, mdc2, o1, o2, oe1, oe2;
  logic [1:0]  st1, st2;

  logic        sel;
  logic        m_rdy, m_vld, m_err, m_mdc, m_o, m_oe;
  logic [15:0] m_rd;

  int n_pass   = 0;
  int n_checks = 0;
  logic [15:0] exp_rd [2];
  logic        exp_err[2];

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdio_ctrl #(.CLK_DIV(4), .PREAMBLE_BITS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg),
    .req_wdata(req_wdata), .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1),
    .mdc(mdc1), .mdio_o(o1), .mdio_oe(oe1), .mdio_i(mdio_i), .state_dbg(st1)
  );

  mdio_ctrl #(.CLK_DIV(2), .PREAMBLE_BITS(0)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rdy2),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg),
    .req_wdata(req_wdata), .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_err(err2),
    .mdc(mdc2), .mdio_o(o2), .mdio_oe(oe2), .mdio_i(mdio_i), .state_dbg(st2)
  );

  assign m_rdy = sel ? rdy2 : rdy1;
  assign m_vld = sel ? vld2 : vld1;
  assign m_err = sel ? err2 : err1;
  assign m_rd  = sel ? rd2  : rd1;
  assign m_mdc = sel ? mdc2 : mdc1;
  assign m_o   = sel ? o2   : o1;
  assign m_oe  = sel ? oe2  : oe1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Idle cycles on both instances: no clock, ready, no response.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_mdc", {mdc1, mdc2}, 2'b00);
      check("idle_ready", {rdy1, rdy2}, 2'b11);
      check("idle_rsp_valid", {vld1, vld2}, 2'b00);
    end
  endtask

  // One transaction on instance `which`, entered and left at a negedge.
  // The PHY model drives mdio_i per bit; `keep` leaves req_valid high with
  // junk fields during the frame so the next call is accepted back-to-back.
  task automatic run_txn(input bit which, input bit wr, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] wd,
                         input bit present, input bit ta_ok,
                         input logic [15:0] pdata, input bit keep);
    int cd, p, n, last, k, ph;
    bit fb[$];
    bit e_oe;
    sel = which;
    cd = which ? 2 : 4;
    p  = which ? 0 : 32;
    n  = p + 32;
    last = (n + 1) * 2 * cd;
    // expected wire bits
    for (int i = 0; i < p; i++) fb.push_back(1'b1);
    fb.push_back(1'b0); fb.push_back(1'b1);
    fb.push_back(!wr);  fb.push_back(wr);
    for (int i = 4; i >= 0; i--) fb.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) fb.push_back(rg[i]);
    fb.push_back(1'b1); fb.push_back(1'b0);
    for (int i = 15; i >= 0; i--) fb.push_back(wd[i]);

    req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
    if (which) rv2 = 1'b1; else rv1 = 1'b1;
    check("ready_at_accept", m_rdy, 1'b1);
    @(posedge clk); #1;
    if (!keep) begin rv1 = 1'b0; rv2 = 1'b0; end
    for (int t = 0; t <= last; t++) begin
      k  = t / (2 * cd);
      ph = t % (2 * cd);
      if (!wr && present && k == p + 15)                 mdio_i = !ta_ok;
      else if (!wr && present && k >= p + 16 && k < n)   mdio_i = pdata[15 - (k - p - 16)];
      else                                               mdio_i = 1'b1;
      if (keep) begin
        req_write = 1'($urandom); req_phy = 5'($urandom);
        req_reg = 5'($urandom); req_wdata = 16'($urandom);
      end
      @(negedge clk);
      e_oe = (k < n) && (wr || k <= p + 13);
      check("mdc", m_mdc, (k <= n) && (ph >= cd));
      check("mdio_oe", m_oe, e_oe);
      if (e_oe)        check("mdio_o", m_o, fb[k]);
      else if (k == n) check("gap_mdio_o", m_o, 1'b1);
      check("rsp_valid", m_vld, t == last);
      check("req_ready", m_rdy, t == last);
      if (t == last) begin
        if (wr) begin
          exp_err[which] = 1'b0;
        end else begin
          exp_rd[which]  = present ? pdata : 16'hFFFF;
          exp_err[which] = !(present && ta_ok);
        end
        check("rsp_rdata", m_rd, exp_rd[which]);
        check("rsp_err", m_err, exp_err[which]);
      end else begin
        @(posedge clk); #1;
      end
    end
    mdio_i = 1'b1;
  endtask

  initial begin : stim
    bit saw_vld;
    reset = 1'b1; rv1 = 1'b0; rv2 = 1'b0; mdio_i = 1'b1; sel = 1'b0;
    req_write = 1'b0; req_phy = '0; req_reg = '0; req_wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset values
    check("rst_ready", {rdy1, rdy2}, 2'b11);
    check("rst_rsp_valid", {vld1, vld2}, 2'b00);
    check("rst_rdata", {rd1, rd2}, 32'h0);
    check("rst_err", {err1, err2}, 2'b00);
    check("rst_mdc", {mdc1, mdc2}, 2'b00);
    check("rst_mdio_o", {o1, o2}, 2'b11);
    check("rst_mdio_oe", {oe1, oe2}, 2'b00);
    reset = 1'b0;
    idle(2);

    // directed frames on the CLK_DIV=4 / 32-bit preamble instance
    run_txn(1'b0, 1'b1, 5'd1, 5'd0, 16'h8000, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(3);
    run_txn(1'b0, 1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 1'b1, 16'h0141, 1'b0);
    idle(1);
    run_txn(1'b0, 1'b0, 5'd3, 5'd1, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(1);
    // bad TA with a PHY otherwise answering
    run_txn(1'b0, 1'b0, 5'd7, 5'd9, 16'h0, 1'b1, 1'b0, 16'h5A3C, 1'b0);
    // back-to-back with req_valid held high through the first frame
    run_txn(1'b0, 1'b1, 5'(($urandom)), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 1'b1);
    run_txn(1'b0, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 1'b1, 16'($urandom), 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              16'($urandom), 1'b0);
      idle($urandom_range(0, 3));
    end

    // reset during bit 20
    sel = 1'b0;
    req_write = 1'b1; req_phy = 5'd4; req_reg = 5'd5; req_wdata = 16'hA5A5;
    rv1 = 1'b1;
    @(posedge clk); #1;
    rv1 = 1'b0;
    repeat (20 * 8 + 3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mdc", mdc1, 1'b0);
    check("mid_rst_mdio_oe", oe1, 1'b0);
    check("mid_rst_mdio_o", o1, 1'b1);
    check("mid_rst_ready", rdy1, 1'b1);
    check("mid_rst_rsp_valid", vld1, 1'b0);
    exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    saw_vld = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (vld1 || vld2) saw_vld = 1'b1;
    end
    check("no_rsp_after_reset", saw_vld, 1'b0);
    check("rdata_after_reset", rd1, 16'h0);

    // CLK_DIV=2, no-preamble instance: 32-bit frames
    run_txn(1'b1, 1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 1'b1, 16'($urandom), 1'b0);
    run_txn(1'b1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              ($urandom_range(0, 3) != 0), 1'b1, 16'($urandom), 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
